qspi_frame_engine: RTL and testbench

Qspi_clk-domain protocol engine for the cartridge host link. It decodes each chip-select frame into a command byte, an optional address field, an optional read turnaround, and then a payload phase that either receives or transmits data. The lane count (1/2/4), address length and dummy cycles are set by parameters. The block contains no CDC: payload moves through external async FIFOs, with this block on the qspi side of both FIFOs.

---
 rtl/qspi_frame_engine_if.sv | 49 ++++
 rtl/qspi_frame_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_qspi_frame_engine.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_frame_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_frame_engine_if
//  Description : Pad, decode-result and FIFO-side signals of the QSPI frame
//                engine. The master modport is the engine; the slave modport
//                is the pad/FIFO/system side. Optional macro QSPI_CRC8_EN
//                adds the crc signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qspi_frame_engine_if #(
    parameter int ADDR_W = 24
);
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic              io_oe;
    logic [7:0]        cmd;
    logic              cmd_valid;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [7:0]        rx_data;
    logic              rx_en;
    logic [7:0]        tx_data;
    logic              tx_empty;
    logic              tx_en;
    logic              underrun;
    logic              busy;
`ifdef QSPI_CRC8_EN
    logic [7:0]        crc;
`endif

    modport master (
        input  io_in, tx_data, tx_empty,
        output io_out, io_oe, cmd, cmd_valid, addr, addr_valid,
        output rx_data, rx_en, tx_en, underrun, busy
`ifdef QSPI_CRC8_EN
        , output crc
`endif
    );

    modport slave (
        output io_in, tx_data, tx_empty,
        input  io_out, io_oe, cmd, cmd_valid, addr, addr_valid,
        input  rx_data, rx_en, tx_en, underrun, busy
`ifdef QSPI_CRC8_EN
        , input crc
`endif
    );
endinterface
`default_nettype wire

// File: rtl/qspi_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_frame_engine
//  Description : qspi_clk-domain frame decoder: command byte, optional
//                address, optional read turnaround, then an unbounded payload
//                phase that either writes an rx FIFO or drains a tx FIFO.
//                Optional macro QSPI_CRC8_EN adds a CRC-8 over the payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_frame_engine #(
    parameter int LANES        = 4,
    parameter int ADDR_BYTES   = 3,
    parameter int DUMMY_CYCLES = 2
) (
    input  wire logic            qspi_clk,
    input  wire logic            qspi_reset,
    qspi_frame_engine_if.master  bus
);
    localparam int         c_BPB    = 8 / LANES;
    localparam int         c_SW     = 8 - LANES;
    localparam int         c_ADDR_W = (ADDR_BYTES > 0) ? 8 * ADDR_BYTES : 8;
    localparam logic [2:0] c_LAST   = 3'(c_BPB - 1);
    localparam logic [2:0] c_ALAST  = (ADDR_BYTES > 0) ? 3'(ADDR_BYTES - 1) : 3'd0;
    localparam logic [3:0] c_DLAST  = (DUMMY_CYCLES > 0) ? 4'(DUMMY_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_CMD   = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DUMMY = 3'd2,
        ST_RECV  = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          beat_q, beat_d;
    logic [c_SW-1:0]     shift_q, shift_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [c_ADDR_W-1:0] addr_q, addr_d;
    logic                addr_valid_q, addr_valid_d;
    logic [2:0]          abyte_q, abyte_d;
    logic [3:0]          dcnt_q, dcnt_d;

    logic                oe_q;
    logic [7:0]          txsh_q;
    logic                miss_q;
    logic                underrun_q;

    logic [7:0]          w_byte;
    logic                w_done;
    logic [c_ADDR_W-1:0] w_addr_next;

    // Completed byte = earlier beats of this byte plus the lanes sampled now
    assign w_byte = {shift_q, bus.io_in[LANES-1:0]};
    assign w_done = (beat_q == c_LAST) && (state_q != ST_DUMMY);

    generate
        if (c_ADDR_W == 8) begin : g_addr_one
            assign w_addr_next = w_byte;
        end else begin : g_addr_multi
            assign w_addr_next = {addr_q[c_ADDR_W-9:0], w_byte};
        end
    endgenerate

    function automatic state_t payload_state(input logic is_write);
        if (is_write)              return ST_RECV;
        else if (DUMMY_CYCLES > 0) return ST_DUMMY;
        else                       return ST_SEND;
    endfunction

    // Sample-side registers: FSM state, beat/byte counters and decode results
    always_ff @(posedge qspi_clk or posedge qspi_reset) begin
        if (qspi_reset) begin
            state_q      <= ST_CMD;
            beat_q       <= '0;
            shift_q      <= '0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            abyte_q      <= '0;
            dcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            shift_q      <= shift_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            abyte_q      <= abyte_d;
            dcnt_q       <= dcnt_d;
        end
    end

    // Next-state decode; the beat counter is frozen at 0 through turnaround
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        shift_d      = shift_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = cmd_valid_q;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        abyte_d      = abyte_q;
        dcnt_d       = dcnt_q;

        if (state_q == ST_DUMMY) begin
            beat_d = '0;
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_q == c_DLAST) begin
                state_d = ST_SEND;
            end
        end else begin
            shift_d = w_byte[c_SW-1:0];
            beat_d  = w_done ? 3'd0 : beat_q + 3'd1;
        end

        case (state_q)
            ST_CMD: begin
                if (w_done) begin
                    cmd_d       = w_byte;
                    cmd_valid_d = 1'b1;
                    state_d     = (ADDR_BYTES > 0) ? ST_ADDR : payload_state(w_byte[0]);
                end
            end
            ST_ADDR: begin
                if (w_done) begin
                    addr_d  = w_addr_next;
                    abyte_d = abyte_q + 3'd1;
                    if (abyte_q == c_ALAST) begin
                        addr_valid_d = 1'b1;
                        state_d      = payload_state(cmd_q[0]);
                    end
                end
            end
            default: ;
        endcase
    end

    // Drive side: load a fresh byte at beat 0, otherwise shift out LANES bits
    always_ff @(negedge qspi_clk or posedge qspi_reset) begin
        if (qspi_reset) begin
            oe_q       <= 1'b0;
            txsh_q     <= 8'hFF;
            miss_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else if (state_q == ST_SEND) begin
            oe_q <= 1'b1;
            if (beat_q == 3'd0) begin
                if (bus.tx_empty) begin
                    txsh_q     <= 8'hFF;
                    miss_q     <= 1'b1;
                    underrun_q <= 1'b1;
                end else begin
                    txsh_q <= bus.tx_data;
                    miss_q <= 1'b0;
                end
            end else begin
                txsh_q <= {txsh_q[c_SW-1:0], {LANES{1'b1}}};
            end
        end
    end

    // Single-lane mode drives io[1]; idle lanes float high
    generate
        if (LANES == 1) begin : g_out_1
            assign bus.io_out = {2'b11, txsh_q[7], 1'b1};
        end else if (LANES == 2) begin : g_out_2
            assign bus.io_out = {2'b11, txsh_q[7:6]};
        end else begin : g_out_4
            assign bus.io_out = txsh_q[7:4];
        end
    endgenerate

    assign bus.io_oe      = oe_q;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.addr       = addr_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.rx_en      = (state_q == ST_RECV) && w_done;
    assign bus.rx_data    = bus.rx_en ? w_byte : 8'h00;
    assign bus.tx_en      = (state_q == ST_SEND) && (beat_q == c_LAST) && !bus.tx_empty && !miss_q;
    assign bus.underrun   = underrun_q;
    assign bus.busy       = (state_q != ST_CMD);

`ifdef QSPI_CRC8_EN
    logic [7:0] sent_q;
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    // Remember the byte currently on the wire so it can be folded in at its end
    always_ff @(negedge qspi_clk or posedge qspi_reset) begin
        if (qspi_reset) begin
            sent_q <= 8'h00;
        end else if ((state_q == ST_SEND) && (beat_q == 3'd0)) begin
            sent_q <= bus.tx_empty ? 8'hFF : bus.tx_data;
        end
    end

    // Accumulate every payload byte at its completing edge
    always_ff @(posedge qspi_clk or posedge qspi_reset) begin
        if (qspi_reset) begin
            crc_q <= 8'h00;
        end else if ((state_q == ST_RECV) && w_done) begin
            crc_q <= crc8_next(crc_q, w_byte);
        end else if ((state_q == ST_SEND) && w_done) begin
            crc_q <= crc8_next(crc_q, sent_q);
        end
    end

    assign bus.crc = crc_q;
`else
    // CRC accumulator absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_qspi_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qspi_frame_engine
//  Description : Self-checking bench for qspi_frame_engine. Three instances:
//                4 lanes / 2 address bytes / 2 dummy clocks, plus 1-lane and
//                2-lane instances with no address or turnaround.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_frame_engine;
    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [3:0] io_drv = 4'h0;
    logic [7:0] tx_data_drv = 8'h00;
    logic       tx_empty_drv = 1'b1;

    always #5 clk = ~clk;

    qspi_frame_engine_if #(.ADDR_W(16)) b4 ();
    qspi_frame_engine_if #(.ADDR_W(8))  b1 ();
    qspi_frame_engine_if #(.ADDR_W(8))  b2 ();

    assign b4.io_in = io_drv;  assign b4.tx_data = tx_data_drv;  assign b4.tx_empty = tx_empty_drv;
    assign b1.io_in = io_drv;  assign b1.tx_data = tx_data_drv;  assign b1.tx_empty = tx_empty_drv;
    assign b2.io_in = io_drv;  assign b2.tx_data = tx_data_drv;  assign b2.tx_empty = tx_empty_drv;

    qspi_frame_engine #(.LANES(4), .ADDR_BYTES(2), .DUMMY_CYCLES(2)) u_dut4 (
        .qspi_clk(clk), .qspi_reset(rst[0]), .bus(b4));
    qspi_frame_engine #(.LANES(1), .ADDR_BYTES(0), .DUMMY_CYCLES(0)) u_dut1 (
        .qspi_clk(clk), .qspi_reset(rst[1]), .bus(b1));
    qspi_frame_engine #(.LANES(2), .ADDR_BYTES(0), .DUMMY_CYCLES(0)) u_dut2 (
        .qspi_clk(clk), .qspi_reset(rst[2]), .bus(b2));

    // Observed view of whichever instance is under test
    int          sel = 0;
    logic [3:0]  m_io_out;
    logic        m_io_oe, m_cmd_valid, m_addr_valid, m_rx_en, m_tx_en, m_underrun, m_busy;
    logic [7:0]  m_cmd, m_rx_data;
    logic [15:0] m_addr;

    always_comb begin
        m_io_out = b4.io_out;  m_io_oe = b4.io_oe;  m_cmd = b4.cmd;  m_cmd_valid = b4.cmd_valid;
        m_addr = b4.addr;  m_addr_valid = b4.addr_valid;  m_rx_data = b4.rx_data;  m_rx_en = b4.rx_en;
        m_tx_en = b4.tx_en;  m_underrun = b4.underrun;  m_busy = b4.busy;
        if (sel == 1) begin
            m_io_out = b1.io_out;  m_io_oe = b1.io_oe;  m_cmd = b1.cmd;  m_cmd_valid = b1.cmd_valid;
            m_addr = {8'h00, b1.addr};  m_addr_valid = b1.addr_valid;  m_rx_data = b1.rx_data;
            m_rx_en = b1.rx_en;  m_tx_en = b1.tx_en;  m_underrun = b1.underrun;  m_busy = b1.busy;
        end else if (sel == 2) begin
            m_io_out = b2.io_out;  m_io_oe = b2.io_oe;  m_cmd = b2.cmd;  m_cmd_valid = b2.cmd_valid;
            m_addr = {8'h00, b2.addr};  m_addr_valid = b2.addr_valid;  m_rx_data = b2.rx_data;
            m_rx_en = b2.rx_en;  m_tx_en = b2.tx_en;  m_underrun = b2.underrun;  m_busy = b2.busy;
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    int         lane_q[$];
    logic [7:0] fifo[$];
    int         oe_cnt, txen_cnt, tick_no, rx_tick;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int lanes_of(input int s);
        return (s == 1) ? 1 : (s == 2) ? 2 : 4;
    endfunction

    function automatic logic [7:0] crc8_model(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    task automatic refresh_tx();
        tx_empty_drv = (fifo.size() == 0);
        tx_data_drv  = tx_empty_drv ? 8'($urandom) : fifo[0];
    endtask

    // One qspi clock: drive io before the posedge, observe after the negedge
    task automatic tick(input logic [3:0] din);
        logic pop;
        int   lane;
        @(negedge clk);
        #1 io_drv = din;
        #1;
        tick_no++;
        if (m_rx_en) begin
            rx_q.push_back(m_rx_data);
            if (rx_tick < 0) rx_tick = tick_no;
        end
        case (sel)
            1:       lane = int'(m_io_out[1]);
            2:       lane = int'(m_io_out[1:0]);
            default: lane = int'(m_io_out);
        endcase
        if (m_io_oe) begin
            oe_cnt++;
            lane_q.push_back(lane);
        end
        if (m_tx_en) txen_cnt++;
        pop = m_tx_en;
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) void'(fifo.pop_front());
        refresh_tx();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int L, bpb;
        logic [3:0] mask, v, r;
        L = lanes_of(sel);
        bpb = 8 / L;
        mask = 4'((1 << L) - 1);
        for (int k = 0; k < bpb; k++) begin
            v = 4'((b >> (8 - L * (k + 1)))) & mask;
            r = 4'($urandom);
            tick((r & ~mask) | v);
        end
    endtask

    // Pulse qspi_reset (ncs high) and open a new frame on instance s
    task automatic start_frame(input int s, input logic [2:0][7:0] fd, input int fn);
        rst = 3'b111;
        sel = s;
        rx_q.delete();  lane_q.delete();  fifo.delete();
        for (int i = 0; i < fn; i++) fifo.push_back(fd[i]);
        oe_cnt = 0;  txen_cnt = 0;  tick_no = 0;  rx_tick = -1;
        refresh_tx();
        repeat (2) @(posedge clk);
        #1 rst[s] = 1'b0;
    endtask

    function automatic logic [7:0] sent_at(input int i);
        int L, bpb;
        logic [7:0] b;
        L = lanes_of(sel);
        bpb = 8 / L;
        if ((i + 1) * bpb > lane_q.size()) return 8'hxx;
        b = 8'h00;
        for (int k = 0; k < bpb; k++) b = 8'((b << L) | 8'(lane_q[i * bpb + k]));
        return b;
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    // Full frame on the 4-lane instance, compared against supplied expectations
    task automatic run_and_check(input logic [7:0] cmd, input logic [15:0] addr, input int n,
                                 input logic [2:0][7:0] d, input int fifo_n,
                                 input logic [2:0][7:0] e, input logic e_under, input int e_txen);
`ifdef QSPI_CRC8_EN
        logic [7:0] crc_exp;
`endif
        start_frame(0, d, cmd[0] ? 0 : fifo_n);
        send_byte(cmd);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        if (cmd[0]) for (int i = 0; i < n; i++) send_byte(d[i]);
        else repeat (2 + 2 * n) tick(4'($urandom));
        chk("cmd", m_cmd, cmd);
        chk("cmd_valid", m_cmd_valid, 1);
        chk("addr", m_addr, addr);
        chk("addr_valid", m_addr_valid, 1);
        chk("busy", m_busy, 1);
        if (cmd[0]) begin
            chk("rx_count", rx_q.size(), n);
            for (int i = 0; i < n; i++) chk("rx_byte", rx_at(i), e[i]);
            chk("oe_cycles_write", oe_cnt, 0);
        end else begin
            chk("rx_count_read", rx_q.size(), 0);
            chk("oe_cycles", oe_cnt, 2 * n);
            for (int i = 0; i < n; i++) chk("tx_byte", sent_at(i), e[i]);
        end
        chk("tx_en_count", txen_cnt, e_txen);
        chk("underrun", m_underrun, e_under);
`ifdef QSPI_CRC8_EN
        crc_exp = 8'h00;
        for (int i = 0; i < n; i++) crc_exp = crc8_model(crc_exp, e[i]);
        chk("crc", b4.crc, crc_exp);
`endif
    endtask

    typedef struct {
        logic [7:0]       cmd;
        logic [15:0]      addr;
        int               n;
        logic [2:0][7:0]  d;
        int               fifo_n;
        logic [2:0][7:0]  e;
        logic             e_under;
        int               e_txen;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0]      r_cmd;
        logic [15:0]     r_addr;
        int              r_n, r_fn, r_txen;
        logic [2:0][7:0] r_d, r_e;
        logic            r_under;
        string           s9;

        tbl[0] = '{8'h81, 16'h1234, 2, 24'h003CA5, 0, 24'h003CA5, 1'b0, 0};
        tbl[1] = '{8'h02, 16'h0000, 2, 24'h00ADDE, 2, 24'h00ADDE, 1'b0, 2};
        tbl[2] = '{8'h02, 16'h0000, 2, 24'h0000DE, 1, 24'h00FFDE, 1'b1, 1};
        tbl[3] = '{8'h0F, 16'hFFFF, 3, 24'h5AFF00, 0, 24'h5AFF00, 1'b0, 0};
        tbl[4] = '{8'h40, 16'hABCD, 3, 24'h000000, 0, 24'hFFFFFF, 1'b1, 0};
        tbl[5] = '{8'hFE, 16'h8001, 3, 24'h7E8001, 3, 24'h7E8001, 1'b0, 3};

        // Zero-clock frame: everything at reset values
        start_frame(0, '0, 0);
        chk("rst_cmd_valid", m_cmd_valid, 0);
        chk("rst_addr_valid", m_addr_valid, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_io_oe", m_io_oe, 0);
        chk("rst_io_out", m_io_out, 4'hF);
        chk("rst_underrun", m_underrun, 0);
        chk("rst_rx_en", m_rx_en, 0);
        chk("rst_tx_en", m_tx_en, 0);
        chk("rst_cmd", m_cmd, 0);
        chk("rst_addr", m_addr, 0);

        for (int v = 0; v < 6; v++)
            run_and_check(tbl[v].cmd, tbl[v].addr, tbl[v].n, tbl[v].d, tbl[v].fifo_n,
                          tbl[v].e, tbl[v].e_under, tbl[v].e_txen);

        // Short address: only one of two address bytes
        start_frame(0, '0, 0);
        send_byte(8'h81);
        send_byte(8'h12);
        chk("short_cmd_valid", m_cmd_valid, 1);
        chk("short_addr_valid", m_addr_valid, 0);
        chk("short_busy", m_busy, 1);
        chk("short_rx", rx_q.size(), 0);

        // Reset after one of two payload beats
        start_frame(0, '0, 0);
        send_byte(8'h81);  send_byte(8'h12);  send_byte(8'h34);
        tick(4'hA);
        #2 rst[0] = 1'b1;
        #1;
        chk("midrst_busy", m_busy, 0);
        chk("midrst_cmd_valid", m_cmd_valid, 0);
        chk("midrst_rx", rx_q.size(), 0);

        // Reset while driving: io_oe must drop without a clock edge
        start_frame(0, 24'h00ADDE, 2);
        send_byte(8'h02);  send_byte(8'h00);  send_byte(8'h00);
        repeat (3) tick(4'h0);
        chk("midrst_oe_before", m_io_oe, 1);
        #2 rst[0] = 1'b1;
        #1;
        chk("midrst_oe_after", m_io_oe, 0);
        chk("midrst_io_out", m_io_out, 4'hF);

        run_and_check(tbl[0].cmd, tbl[0].addr, tbl[0].n, tbl[0].d, tbl[0].fifo_n,
                      tbl[0].e, tbl[0].e_under, tbl[0].e_txen);

        // Nine-byte write; CRC-8 of "123456789" is 0xF4
        s9 = "123456789";
        start_frame(0, '0, 0);
        send_byte(8'h81);  send_byte(8'h00);  send_byte(8'h00);
        for (int i = 0; i < 9; i++) send_byte(s9[i]);
        chk("crcseq_rx_count", rx_q.size(), 9);
        for (int i = 0; i < 9; i++) chk("crcseq_rx_byte", rx_at(i), s9[i]);
`ifdef QSPI_CRC8_EN
        chk("crcseq_crc", b4.crc, 8'hF4);
`endif

        // Single lane: command-only write, then one payload byte
        start_frame(1, '0, 0);
        send_byte(8'h01);
        chk("l1_cmd", m_cmd, 8'h01);
        chk("l1_cmd_valid", m_cmd_valid, 1);
        chk("l1_addr_valid", m_addr_valid, 0);
        chk("l1_cmdonly_rx", rx_q.size(), 0);
        send_byte(8'hC3);
        chk("l1_rx_count", rx_q.size(), 1);
        chk("l1_rx_byte", rx_at(0), 8'hC3);
        chk("l1_rx_tick", rx_tick, 16);
        chk("l1_oe", oe_cnt, 0);

        // Single lane read: data on io[1]
        start_frame(1, 24'h000096, 1);
        send_byte(8'h00);
        repeat (8) tick(4'($urandom));
        chk("l1_oe_cycles", oe_cnt, 8);
        chk("l1_tx_byte", sent_at(0), 8'h96);
        chk("l1_tx_en", txen_cnt, 1);
        chk("l1_underrun", m_underrun, 0);

        // Two lanes: same write takes half the clocks
        start_frame(2, '0, 0);
        send_byte(8'h01);
        send_byte(8'hC3);
        chk("l2_rx_count", rx_q.size(), 1);
        chk("l2_rx_byte", rx_at(0), 8'hC3);
        chk("l2_rx_tick", rx_tick, 8);

        // Random frames against a rule-level model
        for (int t = 0; t < 40; t++) begin
            r_cmd  = 8'($urandom);
            r_addr = 16'($urandom);
            r_n    = int'($urandom_range(1, 3));
            r_d    = 24'($urandom);
            r_fn   = int'($urandom_range(0, r_n));
            r_e    = '0;
            for (int i = 0; i < r_n; i++)
                r_e[i] = (r_cmd[0] || i < r_fn) ? r_d[i] : 8'hFF;
            r_under = !r_cmd[0] && (r_fn < r_n);
            r_txen  = r_cmd[0] ? 0 : r_fn;
            run_and_check(r_cmd, r_addr, r_n, r_d, r_fn, r_e, r_under, r_txen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
